// File: rtl/fetch_stage.sv
// MIPS instruction fetch + IF/ID register: one edge from imem_data to if_id_instr.
// Priority per edge: redirect (flush) > stall (hold) > imem miss (bubble) > normal fetch.
module fetch_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_ready,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic [15:0]       if_id_imm16,
  output logic [DATA_W-1:0] fetch_count
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;

  logic              redirect;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] pc_plus4;

  assign redirect = branch_taken | jump;
  // Branch wins when ID reports both in the same cycle.
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc_q + DATA_W'(4);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d    = {target[DATA_W-1:2], 2'b00};
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!imem_ready) begin
      // Re-present the same address; pc4 keeps its last value.
      instr_d = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign if_id_imm16 = instr_q[15:0];
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed expectations checked with immediate assertions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] if_id_imm16;
  logic [31:0] fetch_count;

  int passed = 0;
  int total  = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .if_id_imm16   (if_id_imm16),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full observable state in one call; imem_addr must always track pc.
  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".imem_addr"}, imem_addr, e_pc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".imm16"}, {16'h0, if_id_imm16}, {16'h0, e_instr[15:0]});
    check({tag, ".pc4"}, if_id_pc4, e_pc4);
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    check({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; imem_data = '0; imem_ready = 1'b0;
    #2;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #5;
    reset = 1'b0; imem_ready = 1'b1; imem_data = 32'h2001_0005;

    step(); check_all("fetch1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);
    step(); check_all("fetch2", 32'h8, 32'h2001_0005, 32'h8, 1'b1, 32'd2);

    // Stall at pc=8 with imem_ready toggling.
    stall = 1'b1; imem_ready = 1'b0;
    step(); check_all("stall1", 32'h8, 32'h2001_0005, 32'h8, 1'b1, 32'd2);
    imem_ready = 1'b1;
    step(); check_all("stall2", 32'h8, 32'h2001_0005, 32'h8, 1'b1, 32'd2);
    stall = 1'b0;
    step(); check_all("unstall", 32'hC, 32'h2001_0005, 32'hC, 1'b1, 32'd3);

    // Negative immediate for the decode sign-extender.
    imem_data = 32'h2001_FFFB;
    step(); check_all("negimm", 32'h10, 32'h2001_FFFB, 32'h10, 1'b1, 32'd4);
    check("sext", {{16{if_id_imm16[15]}}, if_id_imm16}, 32'hFFFF_FFFB);

    // Three misses at pc=0x10, then the held address is fetched.
    imem_ready = 1'b0; imem_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("miss", 32'h10, 32'h0, 32'h10, 1'b0, 32'd4);
    end
    imem_ready = 1'b1; imem_data = 32'hAABB_0010;
    step(); check_all("miss_done", 32'h14, 32'hAABB_0010, 32'h14, 1'b1, 32'd5);

    // Branch + jump + stall together: branch target wins, IF/ID flushed.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h100;
    step(); check_all("redir_both", 32'h40, 32'h0, 32'h0, 1'b0, 32'd5);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_data = 32'h0000_1234;
    step(); check_all("after_redir", 32'h44, 32'h0000_1234, 32'h44, 1'b1, 32'd6);

    // Back-to-back redirects, unaligned branch target masked.
    branch_taken = 1'b1; branch_target = 32'h83;
    step(); check_all("redir_a", 32'h80, 32'h0, 32'h0, 1'b0, 32'd6);
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h200;
    step(); check_all("redir_b", 32'h200, 32'h0, 32'h0, 1'b0, 32'd6);

    // Top-of-memory jump and PC wrap.
    jump_target = 32'hFFFF_FFFE;
    step(); check_all("jmp_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd6);
    jump = 1'b0; imem_data = 32'h1234_5678;
    step(); check_all("wrap", 32'h0, 32'h1234_5678, 32'h0, 1'b1, 32'd7);

    // Async reset mid-cycle during a stall.
    stall = 1'b1;
    step(); check_all("pre_rst", 32'h0, 32'h1234_5678, 32'h0, 1'b1, 32'd7);
    #3; reset = 1'b1;
    #1; check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #3; reset = 1'b0; stall = 1'b0; imem_data = 32'h2001_0005;
    step(); check_all("post_rst", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS pipeline.
- Holds the PC, drives the instruction-memory address and handles the imem ready handshake.
- Applies stall, branch and jump redirects with flush, and registers the fetched instruction.
- if_id_imm16 (instr[15:0]) is the direct input to Sign_Extend (port a) in the decode stage.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- DATA_W, 32, instruction/PC width. Fixed at 32; other values unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall: hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  branch destination address.
- jump  in  1  jump decoded in ID.
- jump_target  in  32  jump destination address.
- imem_addr  out  32  instruction memory address. Combinational = pc.
- imem_data  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  imem_data valid this cycle.
- pc  out  32  current fetch PC (register).
- if_id_instr  out  32  registered instruction (0 = NOP bubble).
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  if_id_instr is a real instruction.
- if_id_imm16  out  16  if_id_instr[15:0], feeds Sign_Extend.
- fetch_count  out  32  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset (async, immediate, any cycle, including mid-stall or mid-redirect):
  - pc=PC_RESET; if_id_instr=0; if_id_pc4=0; if_id_valid=0; fetch_count=0.
  - First fetch occurs on the first rising edge after reset deasserts.
- imem_addr = pc, combinational, no latency.
- Per-edge priority, highest first: redirect > stall > miss > normal.
- Redirect (branch_taken | jump):
  - pc <= target with bits [1:0] forced to 00.
  - Target = branch_target if branch_taken, else jump_target. Branch wins if both are asserted.
  - IF/ID flushed: instr=0, pc4=0, valid=0.
  - Redirect overrides stall in the same cycle.
  - fetch_count unchanged.
- Stall (stall=1, no redirect): pc, IF/ID and fetch_count all hold, regardless of imem_ready.
- Miss (imem_ready=0, no stall, no redirect):
  - pc holds and the same address is re-presented.
  - IF/ID loads a bubble (instr=0, valid=0); if_id_pc4 holds.
- Normal:
  - pc <= pc+4; if_id_instr <= imem_data; if_id_pc4 <= pc+4; if_id_valid <= 1; fetch_count <= fetch_count+1.
- Arithmetic: pc+4 is modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). fetch_count wraps at 2^32.
- Latency: an instruction presented at pc in cycle N appears on if_id_instr in cycle N+1 (one edge).
- if_id_imm16 is a pure wire of if_id_instr[15:0] and carries no additional register.
- No combinational path from stall/branch/jump inputs to any output. imem_addr depends on the pc register only.
- States (implicit, one-hot not required):
  - RUN: normal or miss.
  - HOLD: stall.
  - FLUSH: redirect, one cycle, returning to RUN.
  - Repeated redirects on consecutive cycles are each honoured.

Test Plan:
- Reset, then imem_ready=1 and imem_data=0x2001_0005 for 3 cycles -> pc 0,4,8,12; if_id_instr=0x2001_0005; if_id_pc4 4,8,12; if_id_imm16=0x0005; fetch_count=3.
- Fetch imem_data=0x2001_FFFB -> if_id_imm16=0xFFFB. Downstream Sign_Extend gives 0xFFFF_FFFB.
- stall=1 for 2 cycles at pc=8 with imem_ready toggling -> pc stays 8; IF/ID and fetch_count unchanged. Release -> pc=12 next edge.
- branch_taken=1 and jump=1 with branch_target=0x40 and jump_target=0x100, with stall=1 -> pc=0x40; if_id_valid=0; if_id_instr=0. Next normal edge -> pc=0x44.
- imem_ready=0 for 3 cycles at pc=0x10 -> imem_addr held at 0x10; bubbles with valid=0. Ready again -> instruction from 0x10 is loaded.
- jump_target=0xFFFF_FFFE -> pc=0xFFFF_FFFC. Normal fetch -> pc=0x0, if_id_pc4=0x0.
- Assert reset asynchronously mid-cycle during a stall -> all outputs go to reset values before the next clk edge.
